// File: rtl/uartlite_rx_console.sv
// AXI4-Lite read master that polls an AXI UART Lite core for console output.
// Received non-NUL bytes are buffered in a small stream FIFO. The core's exit
// status is latched, and completion is flagged once the line terminator has been
// received (or the drain timeout expires), so trailing UART text is not lost.
module uartlite_rx_console #(
    parameter int unsigned BASE_ADDR  = 32'h0,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned POLL_GAP   = 4,
    parameter logic [7:0]  TERM_CHAR  = 8'h0A,
    parameter int unsigned DRAIN_TO   = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    // AXI4-Lite read channels
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    // character stream
    output logic [7:0]        char_o,
    output logic              char_valid_o,
    input  logic              char_ready_i,
    // exit handling and status
    input  logic              exit_valid_i,
    input  logic              exit_zero_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              overrun_o,
    output logic              err_o,
    output logic [15:0]       line_cnt_o
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TimerW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam int unsigned DrainW = $clog2(DRAIN_TO + 1);

    localparam logic [ADDR_W-1:0] RxAddr   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] StatAddr = ADDR_W'(BASE_ADDR + 32'd8);
    localparam logic [PtrW:0]     FullCnt  = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [DrainW-1:0] DrainMax = DrainW'(DRAIN_TO);

    typedef enum logic [2:0] {
        StIdle,
        StStatAr,
        StStatR,
        StRxAr,
        StRxR
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     cnt_q, cnt_d;

    logic              exit_q, exit_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              err_q, err_d;
    logic [15:0]       line_cnt_q, line_cnt_d;
    logic [DrainW-1:0] drain_q, drain_d;

    logic              stat_hs;
    logic              rx_hs;
    logic              resp_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_req;
    logic              do_push;
    logic              do_pop;
    logic              term_push;
    logic              idle_expired;
    logic              unused_rdata;

    assign stat_hs      = (state_q == StStatR) & m_axi_rvalid;
    assign rx_hs        = (state_q == StRxR) & m_axi_rvalid;
    assign resp_ok      = (m_axi_rresp == 2'b00);
    assign fifo_full    = (cnt_q == FullCnt);
    assign fifo_empty   = (cnt_q == '0);
    // NUL bytes are read out of the UART but never buffered
    assign push_req     = rx_hs & resp_ok & (m_axi_rdata[7:0] != 8'h00);
    assign do_pop       = ~fifo_empty & char_ready_i;
    assign do_push      = push_req & (~fifo_full | do_pop);
    assign term_push    = do_push & (m_axi_rdata[7:0] == TERM_CHAR);
    assign idle_expired = (32'(timer_q) + 32'd1) >= POLL_GAP;
    assign unused_rdata = ^m_axi_rdata[31:8];

    // FSM state and poll timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // FSM next state: STAT poll, then an RX read only when data waits and there is room
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (idle_expired) state_d = StStatAr;
            end
            StStatAr: begin
                if (m_axi_arready) state_d = StStatR;
            end
            StStatR: begin
                if (m_axi_rvalid) begin
                    if (!resp_ok) begin
                        state_d = StIdle;
                    end else if (m_axi_rdata[0] && !fifo_full) begin
                        state_d = StRxAr;
                    end else if (POLL_GAP == 0) begin
                        state_d = StStatAr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRxAr: begin
                if (m_axi_arready) state_d = StRxR;
            end
            StRxR: begin
                if (m_axi_rvalid) state_d = resp_ok ? StStatAr : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Poll timer counts only while idle and restarts on every entry to idle
    always_comb begin
        timer_d = '0;
        if (state_q == StIdle && !idle_expired) timer_d = timer_q + 1'b1;
    end

    // FSM outputs: address is held constant for the whole AR phase
    always_comb begin
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_rready  = 1'b0;
        unique case (state_q)
            StStatAr: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = StatAddr;
            end
            StRxAr: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = RxAddr;
            end
            StStatR, StRxR: m_axi_rready = 1'b1;
            default: ;
        endcase
    end

    // Character storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= m_axi_rdata[7:0];
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO next state; simultaneous push and pop leaves the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign char_valid_o = ~fifo_empty;
    assign char_o       = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

    // Sticky status, exit latch, line counter and drain timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_q     <= 1'b0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
            line_cnt_q <= '0;
            drain_q    <= '0;
        end else begin
            exit_q     <= exit_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
            line_cnt_q <= line_cnt_d;
            drain_q    <= drain_d;
        end
    end

    // Status next state; a terminator arriving with the exit request still counts
    always_comb begin
        exit_d     = exit_q | exit_valid_i;
        pass_d     = pass_q;
        overrun_d  = overrun_q | (stat_hs & m_axi_rdata[5]);
        err_d      = err_q | ((stat_hs | rx_hs) & ~resp_ok);
        line_cnt_d = line_cnt_q;
        drain_d    = drain_q;
        done_d     = done_q;

        if (exit_valid_i && !exit_q) pass_d = exit_zero_i;
        if (term_push) line_cnt_d = line_cnt_q + 16'd1;

        if (do_push) begin
            drain_d = '0;
        end else if (exit_q && drain_q != DrainMax) begin
            drain_d = drain_q + 1'b1;
        end

        if (term_push && (exit_q || exit_valid_i)) done_d = 1'b1;
        if (exit_q && drain_q == DrainMax) done_d = 1'b1;
    end

    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign overrun_o  = overrun_q;
    assign err_o      = err_q;
    assign line_cnt_o = line_cnt_q;

endmodule

// File: tb/tb_uartlite_rx_console.sv
// Bench for uartlite_rx_console: a behavioural UART Lite AXI slave feeds bytes,
// expected characters go through a scoreboard queue and are compared on pop.
module tb_uartlite_rx_console;

    localparam int unsigned POLL_GAP   = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam logic [3:0]  STAT_A     = 4'h8;
    localparam logic [3:0]  RX_A       = 4'h0;
    localparam logic [7:0]  TERM       = 8'h0A;

    logic        clk;
    logic        rst_n;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  char_o;
    logic        char_valid;
    logic        char_ready;
    logic        exit_valid;
    logic        exit_zero;
    logic        done;
    logic        pass;
    logic        overrun;
    logic        err;
    logic [15:0] line_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // slave model state
    logic [7:0] uart_q[$];
    logic [7:0] exp_q[$];
    int         ar_log_cyc[$];
    logic [3:0] ar_log_addr[$];
    bit         stat_ovr;
    bit         inject_err;
    int         stall_cnt;
    bit         ar_pend;
    bit         r_pend;
    logic [3:0] ar_addr_p;
    logic [3:0] last_ar_addr;
    bit         term_push_flag;

    uartlite_rx_console #(
        .BASE_ADDR (0),
        .ADDR_W    (4),
        .FIFO_DEPTH(FIFO_DEPTH),
        .POLL_GAP  (POLL_GAP),
        .TERM_CHAR (TERM),
        .DRAIN_TO  (4096)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_axi_araddr (araddr),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready),
        .char_o       (char_o),
        .char_valid_o (char_valid),
        .char_ready_i (char_ready),
        .exit_valid_i (exit_valid),
        .exit_zero_i  (exit_zero),
        .done_o       (done),
        .pass_o       (pass),
        .overrun_o    (overrun),
        .err_o        (err),
        .line_cnt_o   (line_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART Lite slave: decisions at the falling edge for the following rising edge
    initial begin
        arready = 1'b1;
        rvalid = 1'b0;
        rdata = '0;
        rresp = '0;
        stat_ovr = 1'b0;
        inject_err = 1'b0;
        stall_cnt = 0;
        ar_pend = 1'b0;
        r_pend = 1'b0;
        ar_addr_p = '0;
        last_ar_addr = '0;
        term_push_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rvalid = 1'b0;
                rdata = '0;
                rresp = '0;
                ar_pend = 1'b0;
                r_pend = 1'b0;
                arready = 1'b1;
                continue;
            end
            if (r_pend) begin
                rvalid = 1'b0;
                rdata = '0;
                rresp = '0;
                r_pend = 1'b0;
            end
            if (ar_pend) begin
                ar_pend = 1'b0;
                rvalid = 1'b1;
                if (inject_err) begin
                    rresp = 2'b10;
                    rdata = '0;
                    inject_err = 1'b0;
                end else if (ar_addr_p == STAT_A) begin
                    rresp = 2'b00;
                    rdata = {26'b0, stat_ovr, 4'b0, (uart_q.size() > 0)};
                end else begin
                    rresp = 2'b00;
                    rdata = (uart_q.size() > 0) ? {24'b0, uart_q.pop_front()} : 32'h0;
                end
            end
            if (stall_cnt > 0) begin
                arready = 1'b0;
                stall_cnt--;
            end else begin
                arready = 1'b1;
            end
            if (arvalid && arready) begin
                ar_pend = 1'b1;
                ar_addr_p = araddr;
                last_ar_addr = araddr;
                ar_log_cyc.push_back(cyc);
                ar_log_addr.push_back(araddr);
            end
            if (rvalid && rready) begin
                r_pend = 1'b1;
                if (last_ar_addr == RX_A && rresp == 2'b00 && rdata[7:0] == TERM)
                    term_push_flag = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // advance to just after the next falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // pop n characters, comparing each against the scoreboard
    task automatic drain_chars(input int n, input int budget, input string tag);
        int got = 0;
        int t = 0;
        logic [7:0] want;
        char_ready = 1'b1;
        while (got < n && t < budget) begin
            if (char_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra got %h want nothing", tag, char_o);
                end else begin
                    want = exp_q.pop_front();
                    if (char_o !== want) begin
                        errors++;
                        $display("FAIL %s_char got %h want %h", tag, char_o, want);
                    end
                end
                got++;
            end
            step();
            t++;
        end
        char_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({arvalid, araddr, rready, char_valid, char_o, done, pass, overrun, err, line_cnt}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {arvalid, araddr, rready, char_valid,
                     char_o, done, pass, overrun, err, line_cnt});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_poll_idle();
        ar_log_cyc.delete();
        ar_log_addr.delete();
        repeat (40) step();
        checks++;
        if (ar_log_cyc.size() < 4) begin
            errors++;
            $display("FAIL poll_count got %0d want >=4", ar_log_cyc.size());
        end
        for (int i = 1; i < ar_log_cyc.size(); i++) begin
            checks++;
            if (ar_log_cyc[i] - ar_log_cyc[i-1] != int'(POLL_GAP) + 2 ||
                ar_log_addr[i] !== STAT_A) begin
                errors++;
                $display("FAIL poll_spacing got %0d/%h want %0d/%h",
                         ar_log_cyc[i] - ar_log_cyc[i-1], ar_log_addr[i], POLL_GAP + 2, STAT_A);
            end
        end
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL poll_char_valid got %b want 0", char_valid);
        end
    endtask

    task automatic test_hello();
        logic [7:0] msg [3];
        msg = '{8'h48, 8'h69, 8'h0A};
        char_ready = 1'b0;
        foreach (msg[i]) begin
            uart_q.push_back(msg[i]);
            exp_q.push_back(msg[i]);
        end
        repeat (60) step();
        drain_chars(3, 100, "hello");
        checks++;
        if (line_cnt !== 16'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL hello_status got line=%0d done=%b want line=1 done=0", line_cnt, done);
        end
    endtask

    task automatic test_exit_pass();
        int t = 0;
        term_push_flag = 1'b0;
        exit_valid = 1'b1;
        exit_zero = 1'b1;
        step();
        exit_valid = 1'b0;
        exit_zero = 1'b0;
        repeat (5) step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL exit_early_done got %b want 0", done);
        end
        uart_q.push_back(TERM);
        exp_q.push_back(TERM);
        while (!term_push_flag && t < 100) begin
            step();
            t++;
        end
        checks++;
        if (!term_push_flag) begin
            errors++;
            $display("FAIL exit_term_seen got 0 want 1");
        end else if (done !== 1'b0) begin
            errors++;
            $display("FAIL exit_done_before_push got %b want 0", done);
        end
        step();
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL exit_done_pass got done=%b pass=%b want 1/1", done, pass);
        end
        drain_chars(1, 50, "exit");
        checks++;
        if (line_cnt !== 16'd2) begin
            errors++;
            $display("FAIL exit_line_cnt got %0d want 2", line_cnt);
        end
    endtask

    task automatic test_backpressure();
        int rx_reads = 0;
        char_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            uart_q.push_back(8'h61 + 8'(i));
            exp_q.push_back(8'h61 + 8'(i));
        end
        repeat (200) step();
        checks++;
        if (uart_q.size() != 20 - FIFO_DEPTH || char_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_buffered got left=%0d valid=%b want left=%0d valid=1",
                     uart_q.size(), char_valid, 20 - FIFO_DEPTH);
        end
        ar_log_addr.delete();
        ar_log_cyc.delete();
        repeat (30) step();
        foreach (ar_log_addr[i]) if (ar_log_addr[i] !== STAT_A) rx_reads++;
        checks++;
        if (rx_reads != 0 || ar_log_addr.size() == 0) begin
            errors++;
            $display("FAIL bp_stat_only got rx=%0d polls=%0d want rx=0 polls>0",
                     rx_reads, ar_log_addr.size());
        end
        drain_chars(20, 600, "bp");
        checks++;
        if (uart_q.size() != 0) begin
            errors++;
            $display("FAIL bp_uart_left got %0d want 0", uart_q.size());
        end
    endtask

    task automatic test_bad_bytes();
        int t = 0;
        char_ready = 1'b0;
        stat_ovr = 1'b1;
        inject_err = 1'b1;
        while (err !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_err got %b want 1", err);
        end
        uart_q.push_back(8'h00);
        uart_q.push_back(8'h41);
        exp_q.push_back(8'h41);
        repeat (40) step();
        drain_chars(1, 50, "bad");
        repeat (10) step();
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_extra_char got %b want 0", char_valid);
        end
        checks++;
        if (overrun !== 1'b1 || err !== 1'b1 || line_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bad_status got ovr=%b err=%b line=%0d want 1/1/2",
                     overrun, err, line_cnt);
        end
        stat_ovr = 1'b0;
    endtask

    task automatic test_stall_reset();
        int t = 0;
        int stalled = 0;
        logic [3:0] addr0;
        stall_cnt = 10;
        while (!(arvalid && !arready) && t < 20) begin
            step();
            t++;
        end
        addr0 = araddr;
        t = 0;
        while (!arready && t < 20) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== addr0) begin
                errors++;
                $display("FAIL stall_hold got v=%b a=%h want v=1 a=%h", arvalid, araddr, addr0);
            end
            stalled++;
            step();
            t++;
        end
        checks++;
        if (stalled < 3) begin
            errors++;
            $display("FAIL stall_cycles got %0d want >=3", stalled);
        end
        uart_q.push_back(8'h5A);
        t = 0;
        while (!(rready && last_ar_addr == RX_A) && t < 100) begin
            step();
            t++;
        end
        checks++;
        if (!(rready && last_ar_addr == RX_A)) begin
            errors++;
            $display("FAIL rst_reach_rx_r got rready=%b want 1", rready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arvalid, araddr, rready, char_valid, char_o, done, pass, overrun, err, line_cnt}
            !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs got %b want 0", {arvalid, araddr, rready,
                     char_valid, char_o, done, pass, overrun, err, line_cnt});
        end
        repeat (2) step();
        rst_n = 1'b1;
        ar_log_addr.delete();
        ar_log_cyc.delete();
        step();
        checks++;
        if ({arvalid, araddr, rready, char_valid, char_o, done, pass, overrun, err, line_cnt}
            !== '0) begin
            errors++;
            $display("FAIL rst_after_outputs got %b want 0", {arvalid, araddr, rready,
                     char_valid, char_o, done, pass, overrun, err, line_cnt});
        end
        t = 0;
        while (ar_log_addr.size() == 0 && t < 30) begin
            step();
            t++;
        end
        checks++;
        if (ar_log_addr.size() == 0) begin
            errors++;
            $display("FAIL rst_first_read got none want %h", STAT_A);
        end else if (ar_log_addr[0] !== STAT_A) begin
            errors++;
            $display("FAIL rst_first_read got %h want %h", ar_log_addr[0], STAT_A);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        char_ready = 1'b0;
        exit_valid = 1'b0;
        exit_zero = 1'b0;
        step();
        test_reset();
        test_poll_idle();
        test_hello();
        test_exit_pass();
        test_backpressure();
        test_bad_bytes();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
